// File: rtl/pwm_l1_pkg.sv
// ============================================================================
// Module : pwm_l1_pkg
// Brief  : Shared constants, counter type and duty->compare scaling for pwm_l1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pwm_l1_pkg;

  localparam int DEF_DATA_WIDTH         = 32;
  localparam int DEF_DATA_WIDTH_DECIMAL = 24;
  localparam int DEF_CNT_WIDTH          = 16;
  localparam int DEF_DT_WIDTH           = 8;

  localparam logic [31:0] ONE_Q = 32'd1 << DEF_DATA_WIDTH_DECIMAL;

  typedef logic [DEF_CNT_WIDTH-1:0] cnt_t;

  // Widths are fixed at the widest supported size; callers extend in and truncate out.
  function automatic logic [31:0] duty_to_cmp(
    input logic signed [63:0] duty,
    input logic        [31:0] period,
    input int                 frac
  );
    logic [63:0] one;
    logic [63:0] clamped;
    logic [95:0] prod;
    one = 64'd1 << frac;
    if (duty[63])
      clamped = '0;
    else if ($unsigned(duty) >= one)
      clamped = one;
    else
      clamped = $unsigned(duty);
    prod = {32'd0, clamped} * {64'd0, period};
    return 32'(prod >> frac);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_l1_deadtime.sv
// ============================================================================
// Module : pwm_l1_deadtime
// Brief  : Rising-edge delay with short-pulse suppression for one gate.
//          Only built when PWM_L1_DEADTIME_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef PWM_L1_DEADTIME_EN
module pwm_l1_deadtime
  import pwm_l1_pkg::*;
#(
  parameter int DT_WIDTH = DEF_DT_WIDTH
) (
  input  logic                aclk,
  input  logic                reset,
  input  logic                i_in,
  input  logic [DT_WIDTH-1:0] i_dt,
  output logic                o_out
);

  logic [DT_WIDTH-1:0] r_run;

  // r_run counts completed high cycles of the raw gate, saturating.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset)
      r_run <= '0;
    else if (!i_in)
      r_run <= '0;
    else if (r_run != {DT_WIDTH{1'b1}})
      r_run <= r_run + DT_WIDTH'(1);
  end

  assign o_out = i_in && (r_run >= i_dt);

endmodule
`endif

`default_nettype wire

// File: rtl/pwm_l1.sv
// ============================================================================
// Module : pwm_l1
// Brief  : Level 1 PWM modulator with shadowed duty/period and sync strobe.
//          Optional dead-time insertion via macro PWM_L1_DEADTIME_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_l1
  import pwm_l1_pkg::*;
#(
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int DATA_WIDTH_DECIMAL = DEF_DATA_WIDTH_DECIMAL,
  parameter int CNT_WIDTH          = DEF_CNT_WIDTH,
  parameter int DT_WIDTH           = DEF_DT_WIDTH
) (
  input  logic                         aclk,
  input  logic                         reset,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] duty,
  input  logic        [CNT_WIDTH-1:0]  period,
`ifdef PWM_L1_DEADTIME_EN
  input  logic        [DT_WIDTH-1:0]   dead_time,
`endif
  output logic                         pwm_h,
  output logic                         pwm_l,
  output logic                         sync
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_period_sh;
  logic [CNT_WIDTH-1:0] r_cmp_sh;
  logic                 r_en_d;
  logic                 r_h_raw;
  logic                 r_l_raw;
  logic                 r_sync;

  logic [CNT_WIDTH-1:0] w_cmp;
  logic                 w_active;
  logic                 w_wrap;
  logic                 w_load;
  logic                 w_h_next;

  assign w_cmp    = CNT_WIDTH'(duty_to_cmp(64'(duty), 32'(period), DATA_WIDTH_DECIMAL));
  assign w_active = en && (r_period_sh >= CNT_WIDTH'(2));
  assign w_wrap   = (r_cnt == r_period_sh - CNT_WIDTH'(1));
  // Inactive cycles keep loading so a valid period is picked up immediately.
  assign w_load   = !w_active || w_wrap || (en && !r_en_d);
  assign w_h_next = (r_cnt < r_cmp_sh);

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_period_sh <= '0;
      r_cmp_sh    <= '0;
      r_en_d      <= 1'b0;
      r_h_raw     <= 1'b0;
      r_l_raw     <= 1'b0;
      r_sync      <= 1'b0;
    end else begin
      r_en_d <= en;
      if (w_load) begin
        r_period_sh <= period;
        r_cmp_sh    <= w_cmp;
      end
      if (!w_active || w_wrap)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      r_sync  <= w_active && (r_cnt == '0);
      r_h_raw <= w_active && w_h_next;
      r_l_raw <= w_active && !w_h_next;
    end
  end

  assign sync = r_sync;

`ifdef PWM_L1_DEADTIME_EN
  logic [DT_WIDTH-1:0] r_dt_sh;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset)
      r_dt_sh <= '0;
    else if (w_load)
      r_dt_sh <= dead_time;
  end

  // Raw gates are complementary, so the delayed pair can never overlap.
  pwm_l1_deadtime #(.DT_WIDTH(DT_WIDTH)) u_dt_h (
    .aclk  (aclk),
    .reset (reset),
    .i_in  (r_h_raw),
    .i_dt  (r_dt_sh),
    .o_out (pwm_h)
  );

  pwm_l1_deadtime #(.DT_WIDTH(DT_WIDTH)) u_dt_l (
    .aclk  (aclk),
    .reset (reset),
    .i_in  (r_l_raw),
    .i_dt  (r_dt_sh),
    .o_out (pwm_l)
  );
`else
  assign pwm_h = r_h_raw;
  assign pwm_l = r_l_raw;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pwm_l1.sv
// ============================================================================
// Module : tb_pwm_l1
// Brief  : Directed, table-driven bench for pwm_l1 (optionally PWM_L1_DEADTIME_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pwm_l1;
  import pwm_l1_pkg::*;

  logic               aclk  = 1'b0;
  logic               reset = 1'b1;
  logic               en    = 1'b0;
  logic signed [31:0] duty  = 32'h0040_0000;
  cnt_t               period = 16'd100;
`ifdef PWM_L1_DEADTIME_EN
  logic [7:0]         dead_time = 8'd0;
`endif
  logic               pwm_h, pwm_l, sync;

  int n_cmp = 0;
  int n_bad = 0;

  pwm_l1 dut (
    .aclk      (aclk),
    .reset     (reset),
    .en        (en),
    .duty      (duty),
    .period    (period),
`ifdef PWM_L1_DEADTIME_EN
    .dead_time (dead_time),
`endif
    .pwm_h     (pwm_h),
    .pwm_l     (pwm_l),
    .sync      (sync)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic signed [31:0] duty;
    int                 period;
    int                 exp_h;
    int                 exp_l;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_sync(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge aclk);
      if (sync) found = 1'b1;
    end
    if (!found) check({name, "_sync_timeout"}, 0, 1);
  endtask

  // Samples p cycles starting at the current negedge; ends on sample p.
  task automatic measure(input int p, output int hc, output int lc,
                         output int sc, output int bc);
    hc = 0; lc = 0; sc = 0; bc = 0;
    for (int i = 0; i < p; i++) begin
      hc += int'(pwm_h);
      lc += int'(pwm_l);
      sc += int'(sync);
      bc += int'(pwm_h && pwm_l);
      @(negedge aclk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int hc, lc, sc, bc;
    bit found;

    vecs[0] = '{32'h0040_0000, 100, 25, 75};
    vecs[1] = '{32'h00C0_0000, 100, 75, 25};
    vecs[2] = '{32'hFFF0_0000, 100, 0, 100};
    vecs[3] = '{32'h0200_0000, 100, 100, 0};
    vecs[4] = '{32'h0080_0000, 10, 5, 5};
    vecs[5] = '{32'h0055_5555, 10, 3, 7};
    vecs[6] = '{32'h0000_0001, 100, 0, 100};
    vecs[7] = '{32'h00FF_FFFF, 100, 99, 1};
    vecs[8] = '{signed'(ONE_Q), 2, 2, 0};
    vecs[9] = '{32'h0080_0000, 2, 1, 1};

    // Reset state
    repeat (3) @(negedge aclk);
    check("reset_h", int'(pwm_h), 0);
    check("reset_l", int'(pwm_l), 0);
    check("reset_sync", int'(sync), 0);
    reset = 1'b0;
    repeat (3) @(negedge aclk);
    check("disabled_outs", int'({pwm_h, pwm_l, sync}), 0);

    // Enable: sync and first high cycle of pwm_h coincide on the first sample
    en = 1'b1;
    @(negedge aclk);
    check("en_rise_sync", int'(sync), 1);
    check("en_rise_h", int'(pwm_h), 1);

    for (int v = 0; v < 10; v++) begin
      duty   = vecs[v].duty;
      period = cnt_t'(vecs[v].period);
      wait_sync($sformatf("vec%0d_a", v));
      wait_sync($sformatf("vec%0d_b", v));
      check($sformatf("vec%0d_h_at_sync", v), int'(pwm_h), int'(vecs[v].exp_h > 0));
      measure(vecs[v].period, hc, lc, sc, bc);
      check($sformatf("vec%0d_h_count", v), hc, vecs[v].exp_h);
      check($sformatf("vec%0d_l_count", v), lc, vecs[v].exp_l);
      check($sformatf("vec%0d_sync_count", v), sc, 1);
      check($sformatf("vec%0d_overlap", v), bc, 0);
      check($sformatf("vec%0d_next_sync", v), int'(sync), 1);
    end

    // Duty change mid-period only applies from the next period
    duty = 32'h0040_0000; period = 16'd100;
    wait_sync("mid_a");
    wait_sync("mid_b");
    hc = 0;
    for (int i = 0; i < 100; i++) begin
      hc += int'(pwm_h);
      if (i == 40) duty = 32'h00C0_0000;
      @(negedge aclk);
    end
    check("mid_old_h_count", hc, 25);
    check("mid_new_sync", int'(sync), 1);
    check("mid_new_h_at_sync", int'(pwm_h), 1);
    measure(100, hc, lc, sc, bc);
    check("mid_new_h_count", hc, 75);

    // en falling: outputs low next cycle, restart with sync on re-enable
    duty = 32'h0040_0000;
    repeat (10) @(negedge aclk);
    en = 1'b0;
    @(negedge aclk);
    check("en_fall_outs", int'({pwm_h, pwm_l, sync}), 0);
    measure(5, hc, lc, sc, bc);
    check("en_low_activity", hc + lc + sc, 0);
    en = 1'b1;
    @(negedge aclk);
    check("re_en_sync", int'(sync), 1);
    check("re_en_h", int'(pwm_h), 1);

    // period=1 is inactive; period=10 recovers within 2 cycles
    period = 16'd1;
    repeat (210) @(negedge aclk);
    measure(20, hc, lc, sc, bc);
    check("period1_activity", hc + lc + sc, 0);
    period = 16'd10;
    found = 1'b0;
    for (int i = 0; i < 2 && !found; i++) begin
      @(negedge aclk);
      if (sync) found = 1'b1;
    end
    check("period10_sync_within_2", int'(found), 1);
    measure(10, hc, lc, sc, bc);
    check("period10_h_count", hc, 2);
    check("period10_l_count", lc, 8);

    // Asynchronous reset mid-period
    period = 16'd100;
    wait_sync("rst_a");
    wait_sync("rst_b");
    repeat (57) @(negedge aclk);
    reset = 1'b1;
    #1;
    check("async_rst_outs", int'({pwm_h, pwm_l, sync}), 0);
    repeat (3) @(negedge aclk);
    reset = 1'b0;
    @(negedge aclk);
    check("rst_rel_sample1_sync", int'(sync), 0);
    @(negedge aclk);
    check("rst_rel_sample2_sync", int'(sync), 1);
    check("rst_rel_sample2_h", int'(pwm_h), 1);
    measure(100, hc, lc, sc, bc);
    check("rst_rel_h_count", hc, 25);
    check("rst_rel_next_sync", int'(sync), 1);

`ifdef PWM_L1_DEADTIME_EN
    dead_time = 8'd5;
    wait_sync("dt_a");
    wait_sync("dt_b");
    measure(100, hc, lc, sc, bc);
    check("dt5_h_count", hc, 20);
    check("dt5_l_count", lc, 70);
    check("dt5_overlap", bc, 0);
    dead_time = 8'd0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
